// File: rtl/branch_ctrl_if.sv
// Branch-side bus between the fetch unit and branch_ctrl.
// The master drives instruction/flag/LUT traffic; the slave returns branch decode and run status.
interface branch_ctrl_if #(
  parameter int IW = 9,
  parameter int TW = 10,
  parameter int CW = 16
);
  logic          Start;
  logic [IW-1:0] Instruction;
  logic          FlagWrite;
  logic          Zero;
  logic          Carry;
  logic          Negative;
  logic          LutWe;
  logic [3:0]    LutAddr;
  logic [TW-1:0] LutData;
  logic          BranchEn;
  logic          ALU_flag;
  logic [TW-1:0] Target;
  logic          Done;
  logic [CW-1:0] TakenCount;

  modport master (
    output Start, Instruction, FlagWrite, Zero, Carry, Negative,
    output LutWe, LutAddr, LutData,
    input  BranchEn, ALU_flag, Target, Done, TakenCount
  );

  modport slave (
    input  Start, Instruction, FlagWrite, Zero, Carry, Negative,
    input  LutWe, LutAddr, LutData,
    output BranchEn, ALU_flag, Target, Done, TakenCount
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch decode, condition-flag store, offset LUT and program run-state tracking
// for the fetch unit. Decode outputs are combinational; flags, LUT, Done and counter are registered.
module branch_ctrl #(
  parameter int            IW         = 9,
  parameter int            TW         = 10,
  parameter logic [2:0]    BR_OPC     = 3'b110,
  parameter logic [IW-1:0] HALT_INSTR = 9'h1FF,
  parameter int            CW         = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  branch_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, HALTED} state_t;

  state_t               state_q, state_d;
  logic [2:0]           flags_q, flags_d;   // {N, C, Z}
  logic [CW-1:0]        taken_q, taken_d;
  logic                 done_q, done_d;
  logic signed [TW-1:0] lut_q [16];

  logic                 is_br;
  logic                 cond_ok;

  function automatic logic cond_eval(input logic [1:0] cond, input logic [2:0] flags);
    case (cond)
      2'b00:   return 1'b1;
      2'b01:   return flags[0];
      2'b10:   return flags[1];
      default: return flags[2];
    endcase
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a restart from RUN wins over HALT
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.Start) state_d = ARMED;
      ARMED:   if (!bus.Start) state_d = RUN;
      RUN: begin
        if (bus.Start)                            state_d = ARMED;
        else if (bus.Instruction == HALT_INSTR)   state_d = HALTED;
      end
      HALTED:  if (bus.Start) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  // Output decode, zero latency so the fetch unit sees it in the same cycle
  always_comb begin
    is_br         = (bus.Instruction[IW-1 -: 3] == BR_OPC) && (state_q == RUN);
    cond_ok       = cond_eval(bus.Instruction[5:4], flags_q);
    bus.BranchEn  = is_br;
    bus.ALU_flag  = is_br & cond_ok;
    bus.Target    = is_br ? lut_q[bus.Instruction[3:0]] : '0;
    bus.Done      = done_q;
    bus.TakenCount = taken_q;
  end

  // Run-scoped state is wiped whenever the FSM (re)enters ARMED
  always_comb begin
    flags_d = flags_q;
    taken_d = taken_q;
    done_d  = done_q;
    if (state_d == ARMED) begin
      flags_d = '0;
      taken_d = '0;
      done_d  = 1'b0;
    end else if (state_q == RUN) begin
      if (bus.FlagWrite)              flags_d = {bus.Negative, bus.Carry, bus.Zero};
      if (bus.BranchEn & bus.ALU_flag) taken_d = sat_inc(taken_q);
      if (state_d == HALTED)          done_d  = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      flags_q <= '0;
      taken_q <= '0;
      done_q  <= 1'b0;
    end else begin
      flags_q <= flags_d;
      taken_q <= taken_d;
      done_q  <= done_d;
    end
  end

  // Offset LUT: writable in any state, reads are not bypassed
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) lut_q[i] <= '0;
    end else if (bus.LutWe) begin
      lut_q[bus.LutAddr] <= bus.LutData;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed-vector bench for branch_ctrl with hand-computed expectations.
module tb_branch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_ctrl_if #(.IW(9), .TW(10), .CW(16)) bif ();

  branch_ctrl dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bif)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_dec(input string tag, input logic be, input logic af, input logic [9:0] tg);
    settle();
    chk({tag, ".BranchEn"}, bif.BranchEn, be);
    chk({tag, ".ALU_flag"}, bif.ALU_flag, af);
    chk({tag, ".Target"},   bif.Target,   tg);
  endtask

  localparam logic [8:0] NOP    = 9'b000_000000;
  localparam logic [8:0] HALT   = 9'h1FF;
  localparam logic [8:0] BR_A5  = 9'b110_00_0101;
  localparam logic [8:0] BR_Z5  = 9'b110_01_0101;
  localparam logic [8:0] BR_C3  = 9'b110_10_0011;
  localparam logic [8:0] BR_N3  = 9'b110_11_0011;
  localparam logic [8:0] BR_A3  = 9'b110_00_0011;

  initial begin
    bif.Start = 1'b0; bif.Instruction = BR_A5; bif.FlagWrite = 1'b0;
    bif.Zero = 1'b0; bif.Carry = 1'b0; bif.Negative = 1'b0;
    bif.LutWe = 1'b0; bif.LutAddr = 4'd0; bif.LutData = 10'd0;

    // 1. reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_dec("rst", 1'b0, 1'b0, 10'h000);
      chk("rst.Done", bif.Done, 1'b0);
      chk("rst.TakenCount", bif.TakenCount, 16'h0000);
    end
    rst = 1'b0;

    // LUT preload while IDLE
    bif.LutWe = 1'b1; bif.LutAddr = 4'd5; bif.LutData = 10'h3FC;
    tick();
    bif.LutAddr = 4'd3; bif.LutData = 10'h004;
    tick();
    bif.LutWe = 1'b0;
    chk_dec("idle_br", 1'b0, 1'b0, 10'h000);

    // 2. start, set Z, branch on Z
    bif.Start = 1'b1; tick();
    chk_dec("armed_br", 1'b0, 1'b0, 10'h000);
    bif.Start = 1'b0; tick();
    bif.Instruction = NOP; bif.FlagWrite = 1'b1; bif.Zero = 1'b1; tick();
    bif.FlagWrite = 1'b0; bif.Zero = 1'b0; bif.Instruction = BR_Z5;
    chk_dec("brz_taken", 1'b1, 1'b1, 10'h3FC);
    tick();
    chk("cnt_after_brz", bif.TakenCount, 16'd1);
    bif.Instruction = BR_C3;
    chk_dec("brc_not_taken", 1'b1, 1'b0, 10'h004);
    tick();
    chk("cnt_after_brc", bif.TakenCount, 16'd1);

    // LUT write in the same cycle as a read returns old data
    bif.Instruction = BR_A3; bif.LutWe = 1'b1; bif.LutAddr = 4'd3; bif.LutData = 10'h02A;
    chk_dec("lut_nobypass", 1'b1, 1'b1, 10'h004);
    tick();
    bif.LutWe = 1'b0;
    chk_dec("lut_new", 1'b1, 1'b1, 10'h02A);
    tick();
    chk("cnt_after_bra", bif.TakenCount, 16'd3);

    // 3. flag write and branch in the same cycle
    bif.Instruction = NOP; bif.FlagWrite = 1'b1; bif.Zero = 1'b0; tick();
    bif.Zero = 1'b1; bif.Instruction = BR_Z5;
    chk_dec("brz_old_flag", 1'b1, 1'b0, 10'h3FC);
    tick();
    bif.FlagWrite = 1'b0; bif.Zero = 1'b0;
    chk_dec("brz_new_flag", 1'b1, 1'b1, 10'h3FC);
    tick();
    chk("cnt_after_z", bif.TakenCount, 16'd4);
    bif.Instruction = NOP; bif.FlagWrite = 1'b1; bif.Negative = 1'b1; tick();
    bif.FlagWrite = 1'b0; bif.Negative = 1'b0; bif.Instruction = BR_N3;
    chk_dec("brn_taken", 1'b1, 1'b1, 10'h02A);
    tick();
    chk("cnt_after_n", bif.TakenCount, 16'd5);

    // 4. HALT
    bif.Instruction = HALT;
    chk_dec("halt_dec", 1'b0, 1'b0, 10'h000);
    chk("done_before", bif.Done, 1'b0);
    tick();
    chk("done_after", bif.Done, 1'b1);
    bif.Instruction = BR_A5;
    chk_dec("halted_br", 1'b0, 1'b0, 10'h000);
    bif.FlagWrite = 1'b1; bif.Zero = 1'b1;
    tick();
    bif.FlagWrite = 1'b0; bif.Zero = 1'b0;
    chk("done_held", bif.Done, 1'b1);
    chk("cnt_held", bif.TakenCount, 16'd5);
    bif.Start = 1'b1; tick();
    chk("done_cleared", bif.Done, 1'b0);
    chk("cnt_cleared", bif.TakenCount, 16'd0);
    bif.Start = 1'b0; tick();
    bif.Instruction = BR_N3;
    chk_dec("flags_cleared_n", 1'b1, 1'b0, 10'h02A);
    bif.Instruction = BR_Z5;
    chk_dec("halted_fw_ignored", 1'b1, 1'b0, 10'h3FC);

    // restart takes priority over HALT
    bif.Instruction = HALT; bif.Start = 1'b1; tick();
    chk("restart_done", bif.Done, 1'b0);
    bif.Start = 1'b0; tick();
    chk("restart_done2", bif.Done, 1'b0);

    // 5. counter saturation
    bif.Instruction = BR_A5;
    chk_dec("sat_start", 1'b1, 1'b1, 10'h3FC);
    chk("sat_cnt0", bif.TakenCount, 16'd0);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", bif.TakenCount, 16'hFFFE);
    tick();
    chk("sat_ffff", bif.TakenCount, 16'hFFFF);
    tick();
    tick();
    chk("sat_hold", bif.TakenCount, 16'hFFFF);

    // 6. reset during RUN with a same-cycle LUT write and Start
    bif.Instruction = NOP; bif.FlagWrite = 1'b1; bif.Negative = 1'b1; tick();
    bif.FlagWrite = 1'b0; bif.Negative = 1'b0;
    rst = 1'b1; bif.LutWe = 1'b1; bif.LutAddr = 4'd5; bif.LutData = 10'h155; bif.Start = 1'b1;
    bif.Instruction = BR_A5;
    tick();
    rst = 1'b0; bif.LutWe = 1'b0; bif.Start = 1'b0;
    chk_dec("mid_rst_idle", 1'b0, 1'b0, 10'h000);
    chk("mid_rst_done", bif.Done, 1'b0);
    chk("mid_rst_cnt", bif.TakenCount, 16'd0);
    bif.Start = 1'b1; tick();
    bif.Start = 1'b0; tick();
    chk_dec("mid_rst_lut5", 1'b1, 1'b1, 10'h000);
    bif.Instruction = BR_A3;
    chk_dec("mid_rst_lut3", 1'b1, 1'b1, 10'h000);
    bif.Instruction = BR_N3;
    chk_dec("mid_rst_flagn", 1'b1, 1'b0, 10'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
